// File: rtl/apb_des_regbank.sv
// APB slave register bank in front of the DES core: operand words, CTRL/STATUS, captured results.
// Implements wait-state insertion, a start/done handshake, a done interrupt and PSLVERR decoding.
module apb_des_regbank #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned NUM_WORDS   = 2,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                        PCLK,
  input  logic                        PRESETn,
  input  logic                        PSEL,
  input  logic                        PENABLE,
  input  logic                        PWRITE,
  input  logic [ADDR_W-1:0]           PADDR,
  input  logic [DATA_W-1:0]           PWDATA,
  output logic [DATA_W-1:0]           PRDATA,
  output logic                        PREADY,
  output logic                        PSLVERR,
  output logic [NUM_WORDS*DATA_W-1:0] operand_o,
  output logic                        start_o,
  input  logic                        core_done_i,
  input  logic [NUM_WORDS*DATA_W-1:0] core_result_i,
  output logic                        irq_o
);

  localparam int unsigned IDX_W   = $clog2(2 * NUM_WORDS + 2);
  localparam int unsigned IdxCtrl = NUM_WORDS;
  localparam int unsigned IdxStat = NUM_WORDS + 1;
  localparam int unsigned IdxRes  = NUM_WORDS + 2;
  localparam int unsigned IdxEnd  = 2 * NUM_WORDS + 2;

  typedef enum logic {StIdle, StAccess} state_e;

  state_e              r_state, w_state_nxt;
  logic [3:0]          r_cnt, w_cnt_nxt;
  logic [DATA_W-1:0]   r_operand [NUM_WORDS];
  logic [DATA_W-1:0]   r_result  [NUM_WORDS];
  logic                r_busy, r_done, r_irq_en, r_irq, r_start;

  logic [IDX_W-1:0]    w_idx;
  int unsigned         w_idx_n;
  logic                w_upper, w_is_op, w_is_ctrl, w_is_stat, w_is_res;
  logic                w_err, w_ready, w_wr;
  logic [DATA_W-1:0]   w_rdata;

  assign w_idx     = PADDR[IDX_W+1:2];
  assign w_idx_n   = 32'(w_idx);
  assign w_upper   = (PADDR >> (IDX_W + 2)) != '0;
  assign w_is_op   = w_idx_n < NUM_WORDS;
  assign w_is_ctrl = w_idx_n == IdxCtrl;
  assign w_is_stat = w_idx_n == IdxStat;
  assign w_is_res  = (w_idx_n >= IdxRes) && (w_idx_n < IdxEnd);

  // A start request while busy is refused outright, including its irq_en update.
  assign w_err = w_upper || (w_idx_n >= IdxEnd) ||
                 (PWRITE && (w_is_res || (w_is_op && r_busy) ||
                             (w_is_ctrl && PWDATA[0] && r_busy)));

  assign w_ready = (r_state == StAccess) && (r_cnt == 4'd0) && PSEL && PENABLE;
  assign w_wr    = w_ready && PWRITE && !w_err;

  assign PREADY  = w_ready;
  assign PSLVERR = w_ready && w_err;
  assign PRDATA  = (w_ready && !w_err) ? w_rdata : '0;
  assign start_o = r_start;
  assign irq_o   = r_irq;

  for (genvar g = 0; g < NUM_WORDS; g++) begin : g_operand
    assign operand_o[g*DATA_W +: DATA_W] = r_operand[g];
  end

  always_comb begin
    w_rdata = '0;
    for (int unsigned i = 0; i < NUM_WORDS; i++) begin
      if (w_idx_n == i) w_rdata = r_operand[i];
      if (w_idx_n == IdxRes + i) w_rdata = r_result[i];
    end
    if (w_is_ctrl) w_rdata = DATA_W'({r_irq_en, 1'b0});
    if (w_is_stat) w_rdata = DATA_W'({r_done, r_busy});
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (PSEL && !PENABLE) begin
          w_state_nxt = StAccess;
          w_cnt_nxt   = 4'(WAIT_STATES);
        end
      end
      StAccess: begin
        if (!PSEL || w_ready) begin
          w_state_nxt = StIdle;
        end else if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= StIdle;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int unsigned i = 0; i < NUM_WORDS; i++) begin
        r_operand[i] <= '0;
        r_result[i]  <= '0;
      end
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
      r_start  <= 1'b0;
    end else begin
      r_start <= 1'b0;
      r_irq   <= r_done & r_irq_en;
      if (w_wr) begin
        for (int unsigned i = 0; i < NUM_WORDS; i++) begin
          if (w_is_op && (w_idx_n == i)) r_operand[i] <= PWDATA;
        end
        if (w_is_ctrl) begin
          r_irq_en <= PWDATA[1];
          if (PWDATA[0]) begin
            r_busy  <= 1'b1;
            r_start <= 1'b1;
          end
        end
        if (w_is_stat && PWDATA[1]) r_done <= 1'b0;
      end
      // Placed after the W1C so a simultaneous completion keeps done set.
      if (core_done_i && r_busy) begin
        for (int unsigned i = 0; i < NUM_WORDS; i++) begin
          r_result[i] <= core_result_i[i*DATA_W +: DATA_W];
        end
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_des_regbank.sv
// Bench for apb_des_regbank: a zero-wait and a two-wait instance on a shared APB bus,
// with expected responses queued at drive time and compared when PREADY appears.
module tb_apb_des_regbank;

  logic        clk = 1'b0;
  logic        presetn;
  logic        psel, penable, pwrite, sel2;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic        core_done;
  logic [63:0] core_result;

  logic        psel0, psel2;
  logic [31:0] prdata0, prdata2;
  logic        pready0, pready2, pslverr0, pslverr2;
  logic [63:0] operand0, operand2;
  logic        start0, start2, irq0, irq2;
  logic        pready, pslverr;
  logic [31:0] prdata;

  assign psel0   = psel & ~sel2;
  assign psel2   = psel & sel2;
  assign pready  = sel2 ? pready2 : pready0;
  assign pslverr = sel2 ? pslverr2 : pslverr0;
  assign prdata  = sel2 ? prdata2 : prdata0;

  always #5 clk = ~clk;

  apb_des_regbank #(.ADDR_W(12), .DATA_W(32), .NUM_WORDS(2), .WAIT_STATES(0)) u_dut0 (
    .PCLK(clk), .PRESETn(presetn), .PSEL(psel0), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0),
    .operand_o(operand0), .start_o(start0), .core_done_i(core_done),
    .core_result_i(core_result), .irq_o(irq0)
  );

  apb_des_regbank #(.ADDR_W(12), .DATA_W(32), .NUM_WORDS(2), .WAIT_STATES(2)) u_dut2 (
    .PCLK(clk), .PRESETn(presetn), .PSEL(psel2), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata2), .PREADY(pready2), .PSLVERR(pslverr2),
    .operand_o(operand2), .start_o(start2), .core_done_i(core_done),
    .core_result_i(core_result), .irq_o(irq2)
  );

  typedef struct packed {
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic        err;
  } vec_t;

  typedef struct {
    string       name;
    logic        chk_rd;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One APB transfer; exp_cyc > 0 also checks which access cycle carries PREADY.
  task automatic apb(input logic inst2, input logic wr, input logic [11:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err,
                     input int exp_cyc, input logic pulse_done, input string name);
    exp_t e;
    exp_t got;
    int   cyc;
    logic seen;
    e.name   = name;
    e.chk_rd = !wr || exp_err;
    e.rdata  = exp_err ? 32'h0 : exp_rd;
    e.err    = exp_err;
    sb_q.push_back(e);
    @(posedge clk); #1;
    sel2 = inst2; psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    @(posedge clk); #1;
    penable = 1'b1;
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (pready) begin
        seen = 1'b1;
        if (pulse_done) core_done = 1'b1;
        got = sb_q.pop_front();
        check({got.name, " pslverr"}, {63'h0, pslverr}, {63'h0, got.err});
        if (got.chk_rd) check({got.name, " prdata"}, {32'h0, prdata}, {32'h0, got.rdata});
        if (exp_cyc > 0) check({got.name, " ready cycle"}, 64'(cyc), 64'(exp_cyc));
      end else begin
        check({name, " prdata before ready"}, {32'h0, prdata}, 64'h0);
        @(posedge clk); #1;
      end
    end
    if (!seen) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s timeout: got no PREADY, expected PREADY within 20 cycles", name);
      void'(sb_q.pop_front());
    end
    @(posedge clk); #1;
    core_done = 1'b0;
    psel = 1'b0;
    penable = 1'b0;
  endtask

  vec_t tbl[12];
  logic seen_ready;

  initial begin
    tbl[0]  = '{1'b1, 12'h000, 32'h0123_4567, 32'h0,          1'b0};
    tbl[1]  = '{1'b1, 12'h004, 32'h89AB_CDEF, 32'h0,          1'b0};
    tbl[2]  = '{1'b0, 12'h000, 32'h0,         32'h0123_4567,  1'b0};
    tbl[3]  = '{1'b0, 12'h004, 32'h0,         32'h89AB_CDEF,  1'b0};
    tbl[4]  = '{1'b0, 12'h008, 32'h0,         32'h0,          1'b0};
    tbl[5]  = '{1'b0, 12'h00C, 32'h0,         32'h0,          1'b0};
    tbl[6]  = '{1'b0, 12'h018, 32'h0,         32'h0,          1'b1};
    tbl[7]  = '{1'b1, 12'h010, 32'h5555_5555, 32'h0,          1'b1};
    tbl[8]  = '{1'b0, 12'h800, 32'h0,         32'h0,          1'b1};
    tbl[9]  = '{1'b0, 12'h010, 32'h0,         32'h0,          1'b0};
    tbl[10] = '{1'b0, 12'h01F, 32'h0,         32'h0,          1'b1};
    tbl[11] = '{1'b0, 12'h003, 32'h0,         32'h0123_4567,  1'b0};

    presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; sel2 = 1'b0;
    paddr = '0; pwdata = '0; core_done = 1'b0; core_result = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset pready0", {63'h0, pready0}, 64'h0);
    check("reset pslverr0", {63'h0, pslverr0}, 64'h0);
    check("reset prdata0", {32'h0, prdata0}, 64'h0);
    check("reset start0", {63'h0, start0}, 64'h0);
    check("reset irq0", {63'h0, irq0}, 64'h0);
    check("reset operand0", operand0, 64'h0);
    check("reset operand2", operand2, 64'h0);
    @(posedge clk); #1;
    presetn = 1'b1;

    // Zero-wait map walk, including the decode error cases.
    for (int i = 0; i < 12; i++) begin
      apb(1'b0, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].rd, tbl[i].err, 1, 1'b0,
          $sformatf("vec%0d", i));
    end
    check("operand_o after writes", operand0, 64'h89AB_CDEF_0123_4567);

    // Two wait states.
    apb(1'b1, 1'b0, 12'h004, 32'h0, 32'h0, 1'b0, 3, 1'b0, "ws2 rd reset");
    apb(1'b1, 1'b1, 12'h004, 32'h0000_A5A5, 32'h0, 1'b0, 3, 1'b0, "ws2 wr");
    apb(1'b1, 1'b0, 12'h004, 32'h0, 32'h0000_A5A5, 1'b0, 3, 1'b0, "ws2 rd back");

    // Start handshake and busy-time errors.
    apb(1'b0, 1'b1, 12'h008, 32'h3, 32'h0, 1'b0, 1, 1'b0, "ctrl start");
    check("start pulse high", {63'h0, start0}, 64'h1);
    @(posedge clk); #1;
    check("start pulse one cycle", {63'h0, start0}, 64'h0);
    apb(1'b0, 1'b0, 12'h00C, 32'h0, 32'h1, 1'b0, 1, 1'b0, "status busy");
    apb(1'b0, 1'b0, 12'h008, 32'h0, 32'h2, 1'b0, 1, 1'b0, "ctrl rd");
    apb(1'b0, 1'b1, 12'h000, 32'hFFFF_FFFF, 32'h0, 1'b1, 1, 1'b0, "op wr busy");
    check("operand unchanged busy", operand0, 64'h89AB_CDEF_0123_4567);
    apb(1'b0, 1'b1, 12'h008, 32'h1, 32'h0, 1'b1, 1, 1'b0, "restart busy");
    check("no second start", {63'h0, start0}, 64'h0);

    // Completion, interrupt and W1C.
    @(posedge clk); #1;
    core_result = 64'hDEAD_BEEF_CAFE_F00D;
    core_done = 1'b1;
    @(posedge clk); #1;
    core_done = 1'b0;
    apb(1'b0, 1'b0, 12'h00C, 32'h0, 32'h2, 1'b0, 1, 1'b0, "status done");
    apb(1'b0, 1'b0, 12'h010, 32'h0, 32'hCAFE_F00D, 1'b0, 1, 1'b0, "result lo");
    apb(1'b0, 1'b0, 12'h014, 32'h0, 32'hDEAD_BEEF, 1'b0, 1, 1'b0, "result hi");
    check("irq set", {63'h0, irq0}, 64'h1);
    apb(1'b0, 1'b1, 12'h00C, 32'h2, 32'h0, 1'b0, 1, 1'b0, "w1c done");
    @(posedge clk); #1;
    check("irq cleared", {63'h0, irq0}, 64'h0);
    apb(1'b0, 1'b0, 12'h00C, 32'h0, 32'h0, 1'b0, 1, 1'b0, "status cleared");
    apb(1'b0, 1'b1, 12'h010, 32'h1, 32'h0, 1'b1, 1, 1'b0, "result wr");
    apb(1'b0, 1'b0, 12'h010, 32'h0, 32'hCAFE_F00D, 1'b0, 1, 1'b0, "result kept");

    // W1C racing a completion: the set wins.
    apb(1'b0, 1'b1, 12'h008, 32'h3, 32'h0, 1'b0, 1, 1'b0, "ctrl start2");
    core_result = 64'h1111_2222_3333_4444;
    apb(1'b0, 1'b1, 12'h00C, 32'h2, 32'h0, 1'b0, 1, 1'b1, "w1c race");
    apb(1'b0, 1'b0, 12'h00C, 32'h0, 32'h2, 1'b0, 1, 1'b0, "status after race");
    apb(1'b0, 1'b0, 12'h010, 32'h0, 32'h3333_4444, 1'b0, 1, 1'b0, "race result");
    apb(1'b0, 1'b1, 12'h00C, 32'h2, 32'h0, 1'b0, 1, 1'b0, "w1c again");

    // A completion while idle is ignored.
    core_result = 64'h5555_6666_7777_8888;
    core_done = 1'b1;
    @(posedge clk); #1;
    core_done = 1'b0;
    apb(1'b0, 1'b0, 12'h00C, 32'h0, 32'h0, 1'b0, 1, 1'b0, "idle done status");
    apb(1'b0, 1'b0, 12'h010, 32'h0, 32'h3333_4444, 1'b0, 1, 1'b0, "idle done result");

    // PSEL dropped mid-access on the wait-state instance.
    @(posedge clk); #1;
    sel2 = 1'b1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h000;
    pwdata = 32'h2222_2222;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    seen_ready = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (pready2) seen_ready = 1'b1;
    end
    check("psel drop no ready", {63'h0, seen_ready}, 64'h0);
    check("psel drop no commit", operand2, 64'h0000_A5A5_0000_0000);
    apb(1'b1, 1'b0, 12'h000, 32'h0, 32'h0, 1'b0, 3, 1'b0, "after psel drop");

    // Reset during the access phase of a write.
    @(posedge clk); #1;
    sel2 = 1'b0; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h000;
    pwdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    penable = 1'b1;
    #2 presetn = 1'b0;
    @(negedge clk);
    check("mid reset pready", {63'h0, pready0}, 64'h0);
    check("mid reset pslverr", {63'h0, pslverr0}, 64'h0);
    check("mid reset prdata", {32'h0, prdata0}, 64'h0);
    check("mid reset start", {63'h0, start0}, 64'h0);
    check("mid reset irq", {63'h0, irq0}, 64'h0);
    check("mid reset operand", operand0, 64'h0);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    presetn = 1'b1;
    check("no commit after reset", operand0, 64'h0);
    apb(1'b0, 1'b1, 12'h004, 32'h1234_5678, 32'h0, 1'b0, 1, 1'b0, "post reset wr");
    apb(1'b0, 1'b0, 12'h004, 32'h0, 32'h1234_5678, 1'b0, 1, 1'b0, "post reset rd");
    check("post reset operand", operand0, 64'h1234_5678_0000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
